// File: rtl/contra_screen_pkg.sv
// rtl/contra_screen_pkg.sv - screen state codes shared by sequencer, overlay mux and game core
package contra_screen_pkg;

    typedef enum logic [1:0] {
        START = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } game_state_t;

    localparam logic [1:0] GS_START = 2'b00;
    localparam logic [1:0] GS_PLAY  = 2'b01;
    localparam logic [1:0] GS_PAUSE = 2'b10;
    localparam logic [1:0] GS_OVER  = 2'b11;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - one-cycle frame tick on each falling edge of active-low VS
module frame_tick_gen (
    input  logic frame_Clk,
    input  logic Reset_n,
    input  logic VS,
    output logic frameTick
);

    logic vs_d;

    always_ff @(posedge frame_Clk) begin
        if (!Reset_n) begin
            vs_d      <= 1'b1;
            frameTick <= 1'b0;
        end else begin
            vs_d      <= VS;
            frameTick <= vs_d & ~VS;
        end
    end

endmodule

// File: rtl/game_screen_sequencer.sv
// rtl/game_screen_sequencer.sv - title/play/over screen FSM with blink, debounce and restart pulse
// Optional PAUSE state is built when GAME_PAUSE_EN is defined.
module game_screen_sequencer
    import contra_screen_pkg::*;
#(
    parameter int BLINK_FRAMES    = 64,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int OVER_FRAMES     = 180
) (
    input  logic       frame_Clk,
    input  logic       Reset_n,
    input  logic       VS,
    input  logic       startBtn,
    input  logic       playerDead,
    output logic [1:0] gameState,
    output logic       blinkOn,
    output logic       frameTick,
    output logic       gameRestart
);

    localparam int BW = $clog2(BLINK_FRAMES);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int OW = $clog2(OVER_FRAMES + 1);

    game_state_t   state;
    logic [BW-1:0] blink_cnt;
    logic [DW-1:0] deb_cnt;
    logic          deb_armed;
    logic [OW-1:0] over_cnt;
    logic          press;

    frame_tick_gen u_frame_tick_gen (
        .frame_Clk (frame_Clk),
        .Reset_n   (Reset_n),
        .VS        (VS),
        .frameTick (frameTick)
    );

    // The qualifying sample itself raises press so the state moves on the very next edge.
    assign press     = frameTick & startBtn & deb_armed & (deb_cnt >= DW'(DEBOUNCE_FRAMES - 1));
    assign gameState = state;

    always_ff @(posedge frame_Clk) begin
        if (!Reset_n) begin
            state       <= START;
            blink_cnt   <= '0;
            blinkOn     <= 1'b1;
            deb_cnt     <= '0;
            deb_armed   <= 1'b1;
            over_cnt    <= '0;
            gameRestart <= 1'b0;
        end else begin
            gameRestart <= 1'b0;

            if (frameTick) begin
                if (startBtn) begin
                    if (deb_cnt != DW'(DEBOUNCE_FRAMES))
                        deb_cnt <= deb_cnt + 1'b1;
                    if (press)
                        deb_armed <= 1'b0;
                end else begin
                    deb_cnt   <= '0;
                    deb_armed <= 1'b1;
                end

                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blinkOn   <= ~blinkOn;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            // Blink restarts from the visible phase on entry to START or OVER.
            case (state)
                START: begin
                    if (press) begin
                        state       <= PLAY;
                        gameRestart <= 1'b1;
                    end
                end
                PLAY: begin
                    if (playerDead) begin
                        state     <= OVER;
                        over_cnt  <= '0;
                        blink_cnt <= '0;
                        blinkOn   <= 1'b1;
                    end
`ifdef GAME_PAUSE_EN
                    else if (press) begin
                        state <= PAUSE;
                    end
`endif
                end
`ifdef GAME_PAUSE_EN
                PAUSE: begin
                    if (press)
                        state <= PLAY;
                end
`endif
                OVER: begin
                    if (press || (frameTick && over_cnt == OW'(OVER_FRAMES - 1))) begin
                        state     <= START;
                        blink_cnt <= '0;
                        blinkOn   <= 1'b1;
                    end else if (frameTick) begin
                        over_cnt <= over_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= START;
                    blink_cnt <= '0;
                    blinkOn   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_screen_sequencer.sv
// tb/tb_game_screen_sequencer.sv - directed scoreboard bench for game_screen_sequencer
module tb_game_screen_sequencer;

`ifdef GAME_PAUSE_EN
    localparam int PAUSED_STATE = 2;
`else
    localparam int PAUSED_STATE = 1;
`endif

    logic       frame_Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       VS = 1'b1;
    logic       startBtn = 1'b0;
    logic       playerDead = 1'b0;
    logic [1:0] gameState;
    logic       blinkOn;
    logic       frameTick;
    logic       gameRestart;

    game_screen_sequencer #(
        .BLINK_FRAMES    (4),
        .DEBOUNCE_FRAMES (2),
        .OVER_FRAMES     (5)
    ) dut (
        .frame_Clk   (frame_Clk),
        .Reset_n     (Reset_n),
        .VS          (VS),
        .startBtn    (startBtn),
        .playerDead  (playerDead),
        .gameState   (gameState),
        .blinkOn     (blinkOn),
        .frameTick   (frameTick),
        .gameRestart (gameRestart)
    );

    always #5 frame_Clk = ~frame_Clk;

    int cyc = 0;
    int ticks = 0;
    int last_tick = -1;
    int restarts = 0;
    int fall_cyc = 0;
    int compared = 0;
    int mismatched = 0;
    int exp_q[$];

    always @(posedge frame_Clk) cyc++;

    always @(negedge frame_Clk) begin
        if (frameTick) begin
            ticks++;
            last_tick = cyc;
        end
        if (gameRestart)
            restarts++;
    end

    task automatic expect_val(input int v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input int obs);
        int e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                mismatched++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    // One frame: VS low for 10 clocks then high for 10; dead pulses playerDead on the tick cycle.
    task automatic run_frame(input bit dead);
        @(posedge frame_Clk); #1 VS = 1'b0; fall_cyc = cyc;
        @(posedge frame_Clk); #1 playerDead = dead;
        @(posedge frame_Clk); #1 playerDead = 1'b0;
        repeat (8) @(posedge frame_Clk);
        #1 VS = 1'b1;
        repeat (10) @(posedge frame_Clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge frame_Clk); #1 Reset_n = 1'b0;
        repeat (2) @(posedge frame_Clk);
        #1 Reset_n = 1'b1;
    endtask

    int t0;
    int r0;

    initial begin
        // 1: reset held 3 clocks with VS toggling
        repeat (3) begin
            @(posedge frame_Clk); #1 VS = ~VS;
        end
        VS = 1'b1;
        @(posedge frame_Clk); #1 Reset_n = 1'b1;
        expect_val(0); check("reset_state", int'(gameState));
        expect_val(1); check("reset_blink", int'(blinkOn));
        expect_val(0); check("reset_ticks", ticks);
        expect_val(0); check("reset_restart", restarts);

        // 2: blink over 8 frames, one tick per VS fall one clock after the first low sample
        t0 = ticks;
        for (int f = 1; f <= 8; f++) begin
            run_frame(1'b0);
            expect_val(1); check("tick_latency", last_tick - fall_cyc);
            if (f == 3 || f == 8) begin
                expect_val(1); check("blink_on_phase", int'({gameState, blinkOn}));
            end
            if (f == 4 || f == 7) begin
                expect_val(0); check("blink_off_phase", int'({gameState, blinkOn}));
            end
        end
        expect_val(8); check("tick_count", ticks - t0);

        // 3: debounce
        startBtn = 1'b1; run_frame(1'b0);
        startBtn = 1'b0; run_frame(1'b0);
        expect_val(0); check("short_press", int'(gameState));
        r0 = restarts;
        startBtn = 1'b1; run_frame(1'b0);
        expect_val(0); check("one_sample", int'(gameState));
        run_frame(1'b0);
        expect_val(1); check("start_to_play", int'(gameState));
        expect_val(1); check("restart_pulse", restarts - r0);
        repeat (10) run_frame(1'b0);
        expect_val(1); check("held_key_state", int'(gameState));
        expect_val(1); check("held_key_restart", restarts - r0);

        // 4: death coincident with a press, then OVER timeout
        startBtn = 1'b0; run_frame(1'b0);
        startBtn = 1'b1; run_frame(1'b0);
        run_frame(1'b1);
        expect_val(7); check("dead_priority", int'({gameState, blinkOn}));
        startBtn = 1'b0;
        repeat (4) run_frame(1'b0);
        expect_val(3); check("over_hold", int'(gameState));
        run_frame(1'b0);
        expect_val(1); check("over_timeout", int'({gameState, blinkOn}));
        expect_val(1); check("over_no_restart", restarts - r0);

        // 5: pause toggle
        startBtn = 1'b1; repeat (2) run_frame(1'b0);
        expect_val(1); check("replay", int'(gameState));
        r0 = restarts;
        startBtn = 1'b0; run_frame(1'b0);
        startBtn = 1'b1; repeat (2) run_frame(1'b0);
        expect_val(PAUSED_STATE); check("press_in_play", int'(gameState));
        startBtn = 1'b0; run_frame(1'b0);
        startBtn = 1'b1; repeat (2) run_frame(1'b0);
        expect_val(1); check("resume", int'(gameState));
        expect_val(0); check("resume_no_restart", restarts - r0);

        // 6: reset mid-debounce discards progress
        do_reset();
        expect_val(0); check("reset_from_play", int'(gameState));
        r0 = restarts;
        run_frame(1'b0);
        do_reset();
        run_frame(1'b0);
        expect_val(0); check("mid_debounce_reset", int'(gameState));
        run_frame(1'b0);
        expect_val(1); check("redebounce_play", int'(gameState));
        expect_val(1); check("redebounce_restart", restarts - r0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
